tx_sr_ctrl: RTL and testbench
=============================

Name: tx_sr_ctrl

Overview:
Transmit-side byte engine for the serial two-wire target interface. It is the counterpart of the receive shift register. The block accepts a parallel byte and drives it MSB-first onto the data line, advancing one bit on each detected SCL falling edge. After the last bit it releases the line and samples the controller's ACK/NACK. It sits between the transaction controller (which supplies bytes) and the SDA output-enable/edge-detect logic.

Parameters:
DATA_WIDTH, 8, bits per transmitted word (≥2)
IDLE_LEVEL, 1, sda_out value whenever the line is released

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tx_load  input  1  request to load tx_data (single-cycle pulse)
tx_data  input  DATA_WIDTH  byte to transmit
falling_edge_found  input  1  one-cycle pulse: SCL falling edge detected
rising_edge_found  input  1  one-cycle pulse: SCL rising edge detected
sda_in  input  1  synchronized SDA level, used for ACK sampling
tx_abort  input  1  stop/bus error: terminate the current byte
sda_out  output  1  SDA drive value
tx_busy  output  1  a byte is in flight (state ≠ IDLE)
load_err  output  1  one-cycle pulse: tx_load arrived while busy and was ignored
ack_done  output  1  one-cycle pulse: ACK slot sampled
ack_received  output  1  1 = ACK (sda_in low in the ACK slot), 0 = NACK; holds until the next ack_done

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, shift register = all 1s, bit counter=0, sda_out=IDLE_LEVEL, tx_busy=0, load_err=0, ack_done=0, ack_received=0. Reset mid-byte aborts immediately, with no ack_done.
- All outputs are registered. Every response below appears on the cycle after the causing input.
- FSM states:
  - IDLE: sda_out=IDLE_LEVEL. On tx_load: shift register ← tx_data, bit counter ← 0, go to SHIFT. On the next cycle sda_out = tx_data[MSB] and tx_busy=1.
  - SHIFT: sda_out = shift register MSB. Each falling_edge_found shifts left by one (LSB filled with 1) and increments the counter. On the falling edge that would make counter = DATA_WIDTH, go to ACK_WAIT and set sda_out=IDLE_LEVEL (line released). rising_edge_found has no effect.
  - ACK_WAIT: sda_out=IDLE_LEVEL. On rising_edge_found: ack_received ← ~sda_in, pulse ack_done, go to ACK_END. falling_edge_found is ignored.
  - ACK_END: on falling_edge_found go to IDLE; tx_busy drops the next cycle.
- Bit counter width is clog2(DATA_WIDTH+1). It never wraps inside a byte.
- tx_load while tx_busy=1: ignored (shift register untouched); pulse load_err.
- tx_load on the same cycle as the ACK_END→IDLE transition: ignored with load_err. A new load is only accepted in IDLE.
- tx_abort has priority over every edge input. In any non-IDLE state the next state is IDLE, sda_out=IDLE_LEVEL, and there is no ack_done. tx_load and tx_abort together in IDLE: abort wins, and the load is dropped silently.
- rising_edge_found and falling_edge_found asserted together (illegal): both are ignored in that cycle.
- Edge pulses in IDLE are ignored.
- Throughput: one byte per (DATA_WIDTH+1) SCL periods. Back-to-back bytes require tx_load in IDLE before the next SCL rising edge.

Test Plan:
1. Reset then load 0xA5 with 8 falling edges interleaved with rising edges: sda_out sampled at each rising edge = 1,0,1,0,0,1,0,1; after the 8th falling edge sda_out=1; rising edge with sda_in=0 → ack_done pulse, ack_received=1; following falling edge → tx_busy=0.
2. Load 0x3C with sda_in=1 in the ACK slot: ack_received=0 (NACK); ack_done pulses exactly once.
3. Load 0xFF, then pulse tx_load with 0x00 after the 3rd falling edge: load_err pulses once, and the remaining bits transmitted are still 1.
4. Load 0x81, assert tx_abort after the 4th falling edge: next cycle sda_out=1 and tx_busy=0, no ack_done; a subsequent load of 0x81 transmits correctly from the MSB.
5. Assert rst asynchronously mid-SHIFT (not clock-aligned): outputs immediately take their reset values; edge pulses applied afterwards cause no sda_out change.
6. Assert rising_edge_found and falling_edge_found together during SHIFT: the counter and sda_out are unchanged; the byte completes with the correct bit count (8 real falling edges).

Source files
------------

// File: rtl/tx_sr_ctrl.sv
// tx_sr_ctrl: transmit byte engine for the two-wire target interface.
// Loads a parallel word, shifts it out MSB-first on SCL falling edges,
// then releases SDA and samples the controller's ACK/NACK on the next
// SCL rising edge. All outputs come straight from flops.
module tx_sr_ctrl #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_load,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  falling_edge_found,
    input  logic                  rising_edge_found,
    input  logic                  sda_in,
    input  logic                  tx_abort,
    output logic                  sda_out,
    output logic                  tx_busy,
    output logic                  load_err,
    output logic                  ack_done,
    output logic                  ack_received
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]         CNT_ZERO = '0;
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] SR_ONES  = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_ACK_WAIT = 2'd2,
        ST_ACK_END  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sda_out_q, sda_out_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  load_err_q, load_err_d;
    logic                  ack_done_q, ack_done_d;
    logic                  ack_received_q, ack_received_d;

    // Qualified edges: simultaneous rising+falling is illegal and ignored.
    logic fall_s;
    logic rise_s;

    // Edge qualification so an illegal double pulse moves nothing.
    always_comb begin
        fall_s = falling_edge_found & ~rising_edge_found;
        rise_s = rising_edge_found & ~falling_edge_found;
    end

    // Next-state, datapath and output computation (outputs follow state_d).
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        ack_done_d     = 1'b0;
        ack_received_d = ack_received_q;

        // A load is accepted only in IDLE; anywhere else it is flagged.
        if (tx_load && (state_q != ST_IDLE)) begin
            load_err_d = 1'b1;
        end else begin
            load_err_d = 1'b0;
        end

        if (tx_abort) begin
            // Abort wins over every edge and over a load in IDLE.
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                shreg_d = SR_ONES;
                cnt_d   = CNT_ZERO;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_load) begin
                        shreg_d = tx_data;
                        cnt_d   = CNT_ZERO;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (fall_s) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b1};
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_ACK_WAIT;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (rise_s) begin
                        ack_received_d = ~sda_in;
                        ack_done_d     = 1'b1;
                        state_d        = ST_ACK_END;
                    end else begin
                        state_d = ST_ACK_WAIT;
                    end
                end
                ST_ACK_END: begin
                    if (fall_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACK_END;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    shreg_d = SR_ONES;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        // SDA is driven only while data bits are in flight; released otherwise.
        if (state_d == ST_SHIFT) begin
            sda_out_d = shreg_d[DATA_WIDTH-1];
        end else begin
            sda_out_d = IDLE_LEVEL;
        end

        tx_busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shreg_q        <= SR_ONES;
            cnt_q          <= CNT_ZERO;
            sda_out_q      <= IDLE_LEVEL;
            tx_busy_q      <= 1'b0;
            load_err_q     <= 1'b0;
            ack_done_q     <= 1'b0;
            ack_received_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            sda_out_q      <= sda_out_d;
            tx_busy_q      <= tx_busy_d;
            load_err_q     <= load_err_d;
            ack_done_q     <= ack_done_d;
            ack_received_q <= ack_received_d;
        end
    end

    assign sda_out      = sda_out_q;
    assign tx_busy      = tx_busy_q;
    assign load_err     = load_err_q;
    assign ack_done     = ack_done_q;
    assign ack_received = ack_received_q;

endmodule

// File: tb/tb_tx_sr_ctrl.sv
// Directed testbench for tx_sr_ctrl with hand-computed expectations.
module tb_tx_sr_ctrl;

    logic       clk;
    logic       rst;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       falling_edge_found;
    logic       rising_edge_found;
    logic       sda_in;
    logic       tx_abort;
    logic       sda_out;
    logic       tx_busy;
    logic       load_err;
    logic       ack_done;
    logic       ack_received;

    int n_vec;
    int n_err;

    tx_sr_ctrl #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_load            (tx_load),
        .tx_data            (tx_data),
        .falling_edge_found (falling_edge_found),
        .rising_edge_found  (rising_edge_found),
        .sda_in             (sda_in),
        .tx_abort           (tx_abort),
        .sda_out            (sda_out),
        .tx_busy            (tx_busy),
        .load_err           (load_err),
        .ack_done           (ack_done),
        .ack_received       (ack_received)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise();
        rising_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
    endtask

    task automatic fall();
        falling_edge_found = 1'b1;
        tick();
        falling_edge_found = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        tx_load = 1'b1;
        tx_data = d;
        tick();
        tx_load = 1'b0;
    endtask

    // Full byte: check each bit at the rising edge, the release, and the ACK slot.
    task automatic send_byte(input logic [7:0] d, input logic ack_lvl, input logic load_at_end);
        load(d);
        check_val("busy_after_load", {31'd0, tx_busy}, 32'd1);
        for (int i = 7; i >= 0; i--) begin
            rise();
            check_val("bit", {31'd0, sda_out}, {31'd0, d[i]});
            check_val("no_ack_in_shift", {31'd0, ack_done}, 32'd0);
            fall();
        end
        check_val("released", {31'd0, sda_out}, 32'd1);
        check_val("busy_ack_wait", {31'd0, tx_busy}, 32'd1);
        sda_in = ack_lvl;
        rise();
        sda_in = 1'b1;
        check_val("ack_done", {31'd0, ack_done}, 32'd1);
        check_val("ack_received", {31'd0, ack_received}, {31'd0, ~ack_lvl});
        tick();
        check_val("ack_done_once", {31'd0, ack_done}, 32'd0);
        check_val("ack_hold", {31'd0, ack_received}, {31'd0, ~ack_lvl});
        if (load_at_end) begin
            tx_load = 1'b1;
            tx_data = 8'h55;
        end else begin
            tx_load = 1'b0;
        end
        fall();
        tx_load = 1'b0;
        check_val("busy_drop", {31'd0, tx_busy}, 32'd0);
        check_val("end_load_err", {31'd0, load_err}, {31'd0, load_at_end});
        tick();
        check_val("stay_idle", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        n_vec              = 0;
        n_err              = 0;
        rst                = 1'b1;
        tx_load            = 1'b0;
        tx_data            = 8'h00;
        falling_edge_found = 1'b0;
        rising_edge_found  = 1'b0;
        sda_in             = 1'b1;
        tx_abort           = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check_val("rst_sda", {31'd0, sda_out}, 32'd1);
        check_val("rst_busy", {31'd0, tx_busy}, 32'd0);
        check_val("rst_lerr", {31'd0, load_err}, 32'd0);
        check_val("rst_ackd", {31'd0, ack_done}, 32'd0);
        check_val("rst_ackr", {31'd0, ack_received}, 32'd0);

        // 1: 0xA5 with ACK.
        send_byte(8'hA5, 1'b0, 1'b0);

        // 2: 0x3C with NACK, plus a load on the ACK_END->IDLE cycle.
        send_byte(8'h3C, 1'b1, 1'b1);

        // 3: load during SHIFT is rejected, remaining bits stay 1.
        load(8'hFF);
        for (int i = 0; i < 3; i++) begin
            rise();
            check_val("ff_bit", {31'd0, sda_out}, 32'd1);
            fall();
        end
        load(8'h00);
        check_val("load_err", {31'd0, load_err}, 32'd1);
        check_val("load_err_sda", {31'd0, sda_out}, 32'd1);
        tick();
        check_val("load_err_pulse", {31'd0, load_err}, 32'd0);
        for (int i = 3; i < 8; i++) begin
            rise();
            check_val("ff_rest", {31'd0, sda_out}, 32'd1);
            fall();
        end
        sda_in = 1'b0;
        rise();
        sda_in = 1'b1;
        check_val("ff_ackd", {31'd0, ack_done}, 32'd1);
        fall();
        check_val("ff_idle", {31'd0, tx_busy}, 32'd0);

        // 4: abort after the 4th falling edge of 0x81.
        load(8'h81);
        for (int i = 0; i < 4; i++) begin
            rise();
            fall();
        end
        check_val("81_bit3", {31'd0, sda_out}, 32'd0);
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
        check_val("abort_sda", {31'd0, sda_out}, 32'd1);
        check_val("abort_busy", {31'd0, tx_busy}, 32'd0);
        check_val("abort_ackd", {31'd0, ack_done}, 32'd0);
        send_byte(8'h81, 1'b0, 1'b0);

        // Abort together with load in IDLE: load dropped silently.
        tx_abort = 1'b1;
        load(8'h12);
        tx_abort = 1'b0;
        check_val("abort_load_busy", {31'd0, tx_busy}, 32'd0);
        check_val("abort_load_lerr", {31'd0, load_err}, 32'd0);

        // 5: asynchronous reset in the middle of SHIFT.
        load(8'hA5);
        fall();
        check_val("pre_rst_sda", {31'd0, sda_out}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_sda", {31'd0, sda_out}, 32'd1);
        check_val("arst_busy", {31'd0, tx_busy}, 32'd0);
        check_val("arst_ackr", {31'd0, ack_received}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rise();
            fall();
            check_val("idle_edges_sda", {31'd0, sda_out}, 32'd1);
            check_val("idle_edges_busy", {31'd0, tx_busy}, 32'd0);
        end

        // 6: simultaneous edges ignored; byte still needs 8 real falls.
        load(8'hA4);
        for (int i = 0; i < 2; i++) begin
            rise();
            fall();
        end
        check_val("a4_bit5", {31'd0, sda_out}, 32'd1);
        rising_edge_found  = 1'b1;
        falling_edge_found = 1'b1;
        tick();
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        check_val("both_edges_sda", {31'd0, sda_out}, 32'd1);
        for (int i = 2; i < 7; i++) begin
            rise();
            fall();
        end
        check_val("a4_bit0", {31'd0, sda_out}, 32'd0);
        check_val("a4_busy7", {31'd0, tx_busy}, 32'd1);
        rise();
        fall();
        check_val("a4_released", {31'd0, sda_out}, 32'd1);
        sda_in = 1'b0;
        rise();
        sda_in = 1'b1;
        check_val("a4_ackd", {31'd0, ack_done}, 32'd1);
        check_val("a4_ackr", {31'd0, ack_received}, 32'd1);
        fall();
        check_val("a4_idle", {31'd0, tx_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
